xor_stream_descrambler32: RTL
=============================

Name: xor_stream_descrambler32

Overview:
- Receive-side counterpart of the XOR scrambling path. It accepts a stream of 32-bit scrambled words and XORs each word with a 32-bit Galois LFSR keystream to recover the plaintext.
- Each frame carries an XOR checksum word as its last word. The block verifies this checksum and reports the result.
- Sits between the bus/DMA input FIFO and the TinyML datapath. Valid/ready handshake on both sides, one registered output stage.

Parameters:
- POLY, 32'h80200003, Galois LFSR feedback mask.
- DEFAULT_SEED, 32'h00000001, substituted whenever a zero seed is loaded.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- SEED_LD  in  1  load SEED this cycle; aborts any frame in progress.
- SEED  in  32  keystream seed.
- IN_VALID  in  1  input word valid.
- IN_READY  out  1  block can accept an input word.
- IN_DATA  in  32  scrambled input word.
- IN_LAST  in  1  marks the frame's checksum word.
- OUT_VALID  out  1  output register holds a word.
- OUT_READY  in  1  downstream accepts the output word.
- OUT_DATA  out  32  descrambled word.
- OUT_LAST  out  1  descrambled checksum word.
- CHK_VALID  out  1  one-cycle pulse: checksum result valid.
- CHK_OK  out  1  checksum matched (held until the next CHK_VALID or reset).
- CHK_SUM  out  32  running XOR of the frame's descrambled payload words.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state=IDLE; seed_reg=DEFAULT_SEED; K=DEFAULT_SEED; acc=0.
  - IN_READY=0, OUT_VALID=0, OUT_DATA=0, OUT_LAST=0.
  - CHK_VALID=0, CHK_OK=0, CHK_SUM=0.
  - RST has priority over every other input.
- Seed load: SEED_LD=1 in any state →
  - s = (SEED==0) ? DEFAULT_SEED : SEED; seed_reg=s and K=s.
  - acc=0; OUT_VALID=0 (pending word discarded); state=RUN next cycle.
  - Any IN_VALID in the same cycle is not accepted.
- States:
  - IDLE: IN_READY=0; leaves only on SEED_LD.
  - RUN: IN_READY = !OUT_VALID | OUT_READY (combinational).
  - DRAIN: IN_READY=0.
- Accept condition: IN_VALID & IN_READY.
- On accept, in the next cycle:
  - d = IN_DATA ^ K; OUT_DATA=d; OUT_LAST=IN_LAST; OUT_VALID=1.
  - K advances one step: K' = (K>>1) ^ (K[0] ? POLY : 0).
  - Zero-cycle combinational path from IN_DATA to OUT_DATA is forbidden; latency is exactly 1 cycle.
- Payload word (IN_LAST=0): acc ^= d.
- Checksum word (IN_LAST=1), next cycle:
  - CHK_VALID=1 for exactly one cycle.
  - CHK_OK = (d == acc).
  - CHK_SUM = acc, the value before this word; acc is not updated with the checksum word.
  - state=DRAIN.
- DRAIN: when OUT_VALID & OUT_READY, or when OUT_VALID=0 →
  - K=seed_reg, acc=0, state=RUN.
  - Every frame therefore starts with keystream seed_reg.
- Output register:
  - Transfer occurs when OUT_VALID & OUT_READY.
  - OUT_VALID clears after a transfer unless a new word is accepted in the same cycle.
  - A simultaneous transfer and accept loads the new word back-to-back, giving full throughput of 1 word/cycle.
  - OUT_DATA and OUT_LAST are stable while OUT_VALID=1 and OUT_READY=0.
- Empty-payload frame (first word has IN_LAST=1): acc=0, so CHK_OK = (d==0).
- Keystream sanity: K never becomes 0, because POLY bit31=1 and the seed is nonzero.

Test Plan:
- Reset: RST=1 for 2 cycles → all outputs 0; IN_READY=0 while IDLE; IN_VALID ignored.
- Good frame: SEED_LD with SEED=1, then inputs 0x12345679, 0x2A8A5556, 0x78AE032F (last) with OUT_READY=1 →
  - OUT_DATA = 0x12345678, 0xAAAA5555, 0xB89E032D, each 1 cycle after its accept.
  - OUT_LAST asserted on the third word only.
  - CHK_VALID pulse with CHK_OK=1 and CHK_SUM=0xB89E032D.
- Bad checksum: repeat the good frame with last word 0x78AE032E → OUT_DATA 0xB89E032C, CHK_OK=0, CHK_SUM=0xB89E032D.
- Backpressure:
  - OUT_READY=0 for 3 cycles mid-frame → IN_READY=0 and OUT_DATA held.
  - On release, traffic continues at 1 word/cycle and the output sequence is unchanged.
- Reseed between frames: a second identical frame right after the first → same outputs (K restarted at 1). IN_READY=0 during DRAIN until the OUT_LAST word transfers.
- Abort and zero seed:
  - SEED_LD with SEED=0 mid-frame → OUT_VALID dropped, acc cleared, K=DEFAULT_SEED.
  - Next input 0x00000001 → OUT_DATA 0x00000000.

Source files
------------

// File: rtl/xor_stream_descrambler32.sv
// ---------------------------------------------------------------------------
// xor_stream_descrambler32
//
// Receive-side XOR descrambler. Each accepted 32-bit word is XORed with a
// 32-bit Galois LFSR keystream. The result appears in a single registered
// output stage one cycle after the accept. Every frame ends with an XOR
// checksum word that is compared against the running XOR of the frame's
// descrambled payload words. Every frame starts from the loaded seed.
//
// Ports:
//   CLK        in   clock, rising edge
//   RST        in   synchronous active-high reset, highest priority
//   SEED_LD    in   load SEED (zero maps to DEFAULT_SEED), aborts any frame
//   SEED       in   keystream seed
//   IN_VALID   in   input word valid
//   IN_READY   out  input word can be accepted this cycle
//   IN_DATA    in   scrambled input word
//   IN_LAST    in   input word is the frame checksum
//   OUT_VALID  out  output register holds a word
//   OUT_READY  in   downstream takes the output word
//   OUT_DATA   out  descrambled word
//   OUT_LAST   out  descrambled word is the checksum word
//   CHK_VALID  out  one-cycle pulse, checksum result available
//   CHK_OK     out  checksum matched (held until next CHK_VALID)
//   CHK_SUM    out  XOR of the frame's descrambled payload words
// ---------------------------------------------------------------------------
module xor_stream_descrambler32 #(
    parameter logic [31:0] POLY         = 32'h80200003,
    parameter logic [31:0] DEFAULT_SEED = 32'h00000001
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SEED_LD,
    input  logic [31:0] SEED,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [31:0] IN_DATA,
    input  logic        IN_LAST,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [31:0] OUT_DATA,
    output logic        OUT_LAST,
    output logic        CHK_VALID,
    output logic        CHK_OK,
    output logic [31:0] CHK_SUM
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e      state_q;
    logic [31:0] seed_q;
    logic [31:0] k_q;
    logic [31:0] acc_q;
    logic        out_valid_q;
    logic [31:0] out_data_q;
    logic        out_last_q;
    logic        chk_valid_q;
    logic        chk_ok_q;
    logic [31:0] chk_sum_q;

    logic [31:0] load_seed;
    logic        out_xfer;
    logic        in_ready;
    logic        accept;
    logic [31:0] descr;
    logic        drain_done;

    // One Galois LFSR step: shift right, fold in the polynomial when a one
    // falls out of bit 0.
    function automatic logic [31:0] lfsr_step(input logic [31:0] k);
        return (k >> 1) ^ (k[0] ? POLY : 32'h0);
    endfunction

    always_comb begin
        load_seed  = (SEED == 32'h0) ? DEFAULT_SEED : SEED;
        out_xfer   = out_valid_q & OUT_READY;
        // A seed load wins over any input in the same cycle, so the input
        // side is not offered as ready then.
        in_ready   = (state_q == StRun) & ~SEED_LD & (~out_valid_q | OUT_READY);
        accept     = IN_VALID & in_ready;
        descr      = IN_DATA ^ k_q;
        drain_done = (state_q == StDrain) & (out_xfer | ~out_valid_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            seed_q      <= DEFAULT_SEED;
            k_q         <= DEFAULT_SEED;
            acc_q       <= 32'h0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_last_q  <= 1'b0;
            chk_valid_q <= 1'b0;
            chk_ok_q    <= 1'b0;
            chk_sum_q   <= 32'h0;
        end else begin
            chk_valid_q <= 1'b0;
            if (SEED_LD) begin
                // Abort: pending output word is dropped, new frame begins.
                seed_q      <= load_seed;
                k_q         <= load_seed;
                acc_q       <= 32'h0;
                out_valid_q <= 1'b0;
                state_q     <= StRun;
            end else begin
                if (accept) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= descr;
                    out_last_q  <= IN_LAST;
                    k_q         <= lfsr_step(k_q);
                    if (IN_LAST) begin
                        // Checksum word is compared, not folded into acc.
                        chk_valid_q <= 1'b1;
                        chk_ok_q    <= (descr == acc_q);
                        chk_sum_q   <= acc_q;
                        state_q     <= StDrain;
                    end else begin
                        acc_q <= acc_q ^ descr;
                    end
                end else if (out_xfer) begin
                    out_valid_q <= 1'b0;
                end

                // No accept can happen in StDrain, so this never collides
                // with the accept branch above.
                if (drain_done) begin
                    k_q     <= seed_q;
                    acc_q   <= 32'h0;
                    state_q <= StRun;
                end
            end
        end
    end

    assign IN_READY  = in_ready;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_LAST  = out_last_q;
    assign CHK_VALID = chk_valid_q;
    assign CHK_OK    = chk_ok_q;
    assign CHK_SUM   = chk_sum_q;

endmodule
